// File: rtl/cache_and_ram.sv
// Direct-mapped, write-through, write-allocate cache in front of a word RAM.
// Interface contract: there is no valid/ready handshake. Every rising edge
// with rst low performs exactly one operation using address/data/mode as
// sampled on that edge (mode=1 write, mode=0 read); nothing ever stalls.
// Reads return on out one edge later for both hit and miss; writes leave out
// untouched. Because every write also updates the RAM, a cache line never
// holds dirty data and eviction simply overwrites the line.
module cache_and_ram #(
  parameter int RAM_WORDS   = 4096,
  parameter int CACHE_LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        mode,
  output logic [31:0] out
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int IW = $clog2(CACHE_LINES);
  localparam int TW = AW - IW;

  // Backing store; cleared at time zero and never touched by rst.
  logic [31:0] ram [RAM_WORDS] = '{default: '0};

  // Cache line storage: valid bits are reset, tag/data are not needed to be.
  logic [CACHE_LINES-1:0] line_valid;
  logic [TW-1:0]          line_tag  [CACHE_LINES];
  logic [31:0]            line_data [CACHE_LINES];

  logic [AW-1:0] ea;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic [31:0]   ram_rd;

  // Upper address bits are deliberately ignored (aliasing modulo RAM_WORDS).
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW];

  // Address decomposition, hit detection and asynchronous RAM read port.
  always_comb begin
    ea     = address[AW-1:0];
    idx    = ea[IW-1:0];
    tag    = ea[AW-1:IW];
    hit    = line_valid[idx] && (line_tag[idx] == tag);
    ram_rd = ram[ea];
  end

  // One operation per edge; rst clears only cache valid bits and out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
      out        <= '0;
    end else if (mode) begin
      ram[ea]         <= data;
      line_valid[idx] <= 1'b1;
      line_tag[idx]   <= tag;
      line_data[idx]  <= data;
    end else if (hit) begin
      out <= line_data[idx];
    end else begin
      out             <= ram_rd;
      line_valid[idx] <= 1'b1;
      line_tag[idx]   <= tag;
      line_data[idx]  <= ram_rd;
    end
  end

endmodule

// File: tb/tb_cache_and_ram.sv
// Directed bench for cache_and_ram: hand-computed expected values for
// write-through/allocate, hits, conflict eviction, aliasing and reset.
module tb_cache_and_ram;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data;
  logic        mode;
  logic [31:0] out;

  int n_compared;
  int n_mismatched;

  cache_and_ram dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data    (data),
    .mode    (mode),
    .out     (out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one operation for exactly one rising edge, then settle.
  task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mode    = m;
    address = a;
    data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_op(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    do_op(1'b0, a, 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst     = 1'b1;
    mode    = 1'b0;
    address = 32'd0;
    data    = 32'd0;

    // Reset state
    #3;
    check("reset_out", out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic write then read, including a high-order aliased address
    wr(32'd0, 32'd14528);
    check("w0_out_held", out, 32'd0);
    wr(32'd2816867292, 32'd526421);
    check("w3036_out_held", out, 32'd0);
    rd(32'd0);
    check("rd0", out, 32'd14528);
    rd(32'd2816867292);
    check("rd3036", out, 32'd526421);

    // Write leaves out unchanged, then overwrite behaviour
    wr(32'd1001425, 32'd25369366);
    check("w2001_out_held", out, 32'd526421);
    rd(32'd1001425);
    check("rd2001", out, 32'd25369366);
    wr(32'd3036, 32'd14528);
    wr(32'd2001, 32'd14528);
    check("w_overwrite_out_held", out, 32'd25369366);
    rd(32'd2001);
    check("rd2001_ovw", out, 32'd14528);
    rd(32'd3036);
    check("rd3036_ovw", out, 32'd14528);

    // Conflict on index 0: 0 and 32 evict each other
    wr(32'd0, 32'd11);
    wr(32'd32, 32'd22);
    rd(32'd0);
    check("conflict_rd0", out, 32'd11);
    rd(32'd32);
    check("conflict_rd32", out, 32'd22);
    rd(32'd32);
    check("conflict_rd32_hit", out, 32'd22);
    rd(32'd0);
    check("conflict_rd0_again", out, 32'd11);

    // Aliasing modulo RAM_WORDS and never-written address
    wr(32'd4101, 32'd77);
    rd(32'd5);
    check("alias_rd5", out, 32'd77);
    rd(32'd100);
    check("unwritten_rd100", out, 32'd0);
    rd(32'd8292);
    check("alias_rd100_hi", out, 32'd0);

    // Reset between edges clears out immediately, RAM survives
    wr(32'd7, 32'd99);
    rd(32'd7);
    check("rst_pre_rd7", out, 32'd99);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_out", out, 32'd0);
    #1;
    rst = 1'b0;
    rd(32'd7);
    check("rst_post_rd7", out, 32'd99);

    // Write attempted with rst held across an edge must be dropped
    @(negedge clk);
    rst     = 1'b1;
    mode    = 1'b1;
    address = 32'd7;
    data    = 32'd1234;
    @(posedge clk);
    #1;
    check("rst_hold_out", out, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    mode = 1'b0;
    rd(32'd7);
    check("rst_blocked_write_rd7", out, 32'd99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
